cpu_alu: RTL and testbench

// - 16-bit integer ALU for the CPU-Core datapath, between register-file read ports and write-back.
// - Combinational result selected by a 4-bit op code.
// - Registered status flags (Z/N/C/V) on the single core clock, for use by branch logic.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_addsub.sv | 37 +++
 rtl/cpu_alu.sv | 127 ++++++++++++
 tb/tb_cpu_alu.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the CPU-Core ALU.
// Contents:
//   ALU_WIDTH  - default datapath width
//   alu_op_e   - 4-bit op codes (codes 1001..1111 are reserved and behave as PASS)
//   FLAG_*     - bit positions of Z/N/C/V inside the 4-bit flags vector {Z,N,C,V}
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SHL  = 4'b0010,
        ALU_SHR  = 4'b0011,
        ALU_AND  = 4'b0100,
        ALU_OR   = 4'b0101,
        ALU_XOR  = 4'b0110,
        ALU_CMP  = 4'b0111,
        ALU_PASS = 4'b1000
    } alu_op_e;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_addsub.sv
// WIDTH-bit adder/subtractor shared by ADD, SUB and CMP.
// Ports:
//   a, b      operands
//   sub       1: compute a-b as a + ~b + 1; 0: compute a+b
//   sum       WIDTH-bit wrapped result
//   carry     carry-out; for subtraction this is 1 when no borrow (a >= b)
//   overflow  signed overflow of the operation
module alu_addsub #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    logic [WIDTH-1:0] b_eff_s;
    logic [WIDTH:0]   total_s;

    // Invert operand B for subtraction and add the carry-in.
    always_comb begin
        if (sub) begin
            b_eff_s = ~b;
        end else begin
            b_eff_s = b;
        end
        total_s = {1'b0, a} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, sub};
    end

    assign sum      = total_s[WIDTH-1:0];
    assign carry    = total_s[WIDTH];
    // Overflow when both effective operands share a sign that the result lacks.
    assign overflow = (a[WIDTH-1] == b_eff_s[WIDTH-1]) && (total_s[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/cpu_alu.sv
// 16-bit integer ALU: combinational result mux plus registered Z/N/C/V flags.
// Ports:
//   clk      core clock; flags update on rising edge
//   rst      asynchronous active-high reset; clears flags only
//   in0      operand A
//   in1      operand B, also the full shift amount
//   select   op code (see alu_pkg::alu_op_e)
//   flag_en  1: flags capture this cycle's result on the rising edge
//   out      combinational result
//   flags    registered {Z,N,C,V}
module cpu_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [3:0]       select,
    input  logic             flag_en,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       flags
);

    localparam int SHW = $clog2(WIDTH);

    logic             sub_s;
    logic [WIDTH-1:0] sum_s;
    logic             add_c_s;
    logic             add_v_s;
    logic [SHW-1:0]   shamt_s;
    logic             in_range_s;
    logic [WIDTH:0]   shl_wide_s;
    logic [WIDTH:0]   shr_wide_s;
    logic [WIDTH-1:0] result_s;
    logic             c_s;
    logic             v_s;
    logic [3:0]       next_flags_s;
    logic [3:0]       flags_r;

    // Adder runs in subtract mode for SUB and CMP.
    always_comb begin
        if ((select == ALU_SUB) || (select == ALU_CMP)) begin
            sub_s = 1'b1;
        end else begin
            sub_s = 1'b0;
        end
    end

    alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a        (in0),
        .b        (in1),
        .sub      (sub_s),
        .sum      (sum_s),
        .carry    (add_c_s),
        .overflow (add_v_s)
    );

    // Shifts use one extra bit to catch the last bit shifted out; any amount
    // with bits above the low SHW bits is >= WIDTH and forces result and carry to 0.
    assign shamt_s    = in1[SHW-1:0];
    assign in_range_s = ((in1 >> SHW) == {WIDTH{1'b0}});
    assign shl_wide_s = {1'b0, in0} << shamt_s;
    assign shr_wide_s = {in0, 1'b0} >> shamt_s;

    // Result mux and C/V selection; reserved codes fall through to PASS.
    always_comb begin
        result_s = in1;
        c_s      = 1'b0;
        v_s      = 1'b0;
        case (select)
            ALU_ADD, ALU_SUB, ALU_CMP: begin
                result_s = sum_s;
                c_s      = add_c_s;
                v_s      = add_v_s;
            end
            ALU_SHL: begin
                if (in_range_s) begin
                    result_s = shl_wide_s[WIDTH-1:0];
                    c_s      = shl_wide_s[WIDTH];
                end else begin
                    result_s = {WIDTH{1'b0}};
                    c_s      = 1'b0;
                end
            end
            ALU_SHR: begin
                if (in_range_s) begin
                    result_s = shr_wide_s[WIDTH:1];
                    c_s      = shr_wide_s[0];
                end else begin
                    result_s = {WIDTH{1'b0}};
                    c_s      = 1'b0;
                end
            end
            ALU_AND:  result_s = in0 & in1;
            ALU_OR:   result_s = in0 | in1;
            ALU_XOR:  result_s = in0 ^ in1;
            ALU_PASS: result_s = in1;
            default:  result_s = in1;
        endcase
    end

    // Assemble the flag vector from the current result.
    always_comb begin
        next_flags_s         = 4'b0000;
        next_flags_s[FLAG_Z] = (result_s == {WIDTH{1'b0}});
        next_flags_s[FLAG_N] = result_s[WIDTH-1];
        next_flags_s[FLAG_C] = c_s;
        next_flags_s[FLAG_V] = v_s;
    end

    // Flag register: async clear, capture when enabled, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_r <= 4'b0000;
        end else if (flag_en) begin
            flags_r <= next_flags_s;
        end else begin
            flags_r <= flags_r;
        end
    end

    assign out   = result_s;
    assign flags = flags_r;

endmodule

// File: tb/tb_cpu_alu.sv
// Directed self-checking bench for cpu_alu.
module tb_cpu_alu;

    logic        clk;
    logic        rst;
    logic [15:0] in0;
    logic [15:0] in1;
    logic [3:0]  select;
    logic        flag_en;
    logic [15:0] out;
    logic [3:0]  flags;

    int checks;
    int failures;

    cpu_alu #(.WIDTH(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .in0     (in0),
        .in1     (in1),
        .select  (select),
        .flag_en (flag_en),
        .out     (out),
        .flags   (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    // Capture flags for one op on one enabled edge; flag_en drops afterwards.
    task automatic capture(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        select  = op;
        in0     = a;
        in1     = b;
        flag_en = 1'b1;
        @(posedge clk);
        #1;
        flag_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        checks++;
        if (flags !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags: got %b expected %b", flags, 4'b0000);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_ops();
        logic [15:0] exp_tab [0:15];
        exp_tab = '{16'd17, 16'd9, 16'd208, 16'd0, 16'd4, 16'd13, 16'd9, 16'd9,
                    16'd4, 16'd4, 16'd4, 16'd4, 16'd4, 16'd4, 16'd4, 16'd4};
        in0 = 16'd13;
        in1 = 16'd4;
        for (int i = 0; i < 16; i++) begin
            select = 4'(i);
            #2;
            checks++;
            if (out !== exp_tab[i]) begin
                failures++;
                $display("FAIL op_%0d: out got %0d expected %0d", i, out, exp_tab[i]);
            end
        end
    endtask

    task automatic test_wrap();
        capture(4'b0001, 16'd4, 16'd13);
        checks++;
        if (out !== 16'hFFF7 || flags !== 4'b0100) begin
            failures++;
            $display("FAIL sub_wrap: out %h flags %b expected FFF7 0100", out, flags);
        end
        capture(4'b0000, 16'hFFFF, 16'd1);
        checks++;
        if (out !== 16'h0000 || flags !== 4'b1010) begin
            failures++;
            $display("FAIL add_carry: out %h flags %b expected 0000 1010", out, flags);
        end
        capture(4'b0000, 16'h7FFF, 16'd1);
        checks++;
        if (out !== 16'h8000 || flags !== 4'b0101) begin
            failures++;
            $display("FAIL add_ovf: out %h flags %b expected 8000 0101", out, flags);
        end
    endtask

    task automatic test_shift();
        logic [3:0]  op_tab  [0:5];
        logic [15:0] a_tab   [0:5];
        logic [15:0] b_tab   [0:5];
        logic [15:0] exp_tab [0:5];
        op_tab  = '{4'b0010, 4'b0010, 4'b0011, 4'b0010, 4'b0011, 4'b0011};
        a_tab   = '{16'd1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h8000};
        b_tab   = '{16'd15, 16'd16, 16'd16, 16'hFFFF, 16'hFFFF, 16'd15};
        exp_tab = '{16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0001};
        for (int i = 0; i < 6; i++) begin
            select = op_tab[i];
            in0    = a_tab[i];
            in1    = b_tab[i];
            #2;
            checks++;
            if (out !== exp_tab[i]) begin
                failures++;
                $display("FAIL shift_%0d: out got %h expected %h", i, out, exp_tab[i]);
            end
        end
        // Carry out of shifts: last bit shifted out, 0 for amount >= WIDTH.
        capture(4'b0010, 16'hC000, 16'd1);
        checks++;
        if (flags !== 4'b0110) begin
            failures++;
            $display("FAIL shl_carry: flags %b expected 0110", flags);
        end
        capture(4'b0011, 16'h0003, 16'd2);
        checks++;
        if (flags !== 4'b1010) begin
            failures++;
            $display("FAIL shr_carry: flags %b expected 1010", flags);
        end
        capture(4'b0010, 16'hFFFF, 16'd16);
        checks++;
        if (flags !== 4'b1000) begin
            failures++;
            $display("FAIL shl_big_carry: flags %b expected 1000", flags);
        end
    endtask

    task automatic test_flags_hold();
        capture(4'b0001, 16'd13, 16'd13);
        checks++;
        if (flags !== 4'b1010) begin
            failures++;
            $display("FAIL sub_equal: flags %b expected 1010", flags);
        end
        @(negedge clk);
        select = 4'b0000;
        in0    = 16'd13;
        in1    = 16'd4;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (flags !== 4'b1010) begin
            failures++;
            $display("FAIL flags_hold: flags %b expected 1010", flags);
        end
    endtask

    task automatic test_reset_mid_run();
        capture(4'b0001, 16'd4, 16'd13);
        @(negedge clk);
        select = 4'b0110;
        in0    = 16'd13;
        in1    = 16'd4;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (flags !== 4'b0000) begin
            failures++;
            $display("FAIL mid_reset_flags: flags %b expected 0000", flags);
        end
        checks++;
        if (out !== 16'd9) begin
            failures++;
            $display("FAIL mid_reset_out: out %0d expected 9", out);
        end
        @(negedge clk);
        rst = 1'b0;
        capture(4'b0000, 16'hFFFF, 16'd1);
        checks++;
        if (flags !== 4'b1010) begin
            failures++;
            $display("FAIL post_reset_capture: flags %b expected 1010", flags);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        in0      = 16'd0;
        in1      = 16'd0;
        select   = 4'b0000;
        flag_en  = 1'b0;
        test_reset();
        test_ops();
        test_wrap();
        test_shift();
        test_flags_hold();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
